// File: rtl/fd_sched.sv
// fd_sched: single-clock scheduled frequency divider with start/stop sequencing
// and a glitch-free ratio-change handshake (new ratio applies on a period boundary).
// Ports:
//   clk, rst         - system clock, synchronous active-high reset
//   start, stop      - pulses: begin/resume dividing, finish current period then idle
//   cfg_valid/ready  - ratio offer handshake; cfg_div is the requested ratio N
//   cfg_err          - one-cycle pulse after an offered ratio of 0 was rejected
//   busy             - counter active (RUN or DRAIN)
//   tick             - high in the last cycle of each output period
//   clk_out          - registered divided square wave (ceil(N/2) high, floor(N/2) low)
//   cur_div          - ratio currently in effect
//   periods          - completed-period count
// Optional feature: define FD_SCHED_PERIODS_EN to build the 16-bit period counter;
// without it, periods is tied to 0.
module fd_sched #(
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_err,
  output logic             busy,
  output logic             tick,
  output logic             clk_out,
  output logic [WIDTH-1:0] cur_div,
  output logic [15:0]      periods
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] div_nxt;
  logic             pend, pend_nxt;
  logic [WIDTH-1:0] pend_div, pend_div_nxt;
  logic             busy_nxt;
  logic             acc_ok;
  logic             err_nxt;
  logic             clk_out_nxt;

  assign busy      = (state != IDLE);
  assign tick      = busy && (cnt == cur_div - 1'b1);
  // Only one ratio can be waiting; the slot frees at the wrap that consumes it.
  assign cfg_ready = ~pend;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    div_nxt      = cur_div;
    pend_nxt     = pend;
    pend_div_nxt = pend_div;
    acc_ok       = cfg_valid && cfg_ready && (cfg_div != '0);
    err_nxt      = cfg_valid && cfg_ready && (cfg_div == '0);

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = tick ? '0 : cnt + 1'b1;
        if (stop) state_nxt = DRAIN;
      end
      DRAIN: begin
        // A start while draining cancels the stop without restarting the period.
        cnt_nxt = tick ? '0 : cnt + 1'b1;
        if (start)     state_nxt = RUN;
        else if (tick) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Pending ratio is consumed at the wrap, even if that wrap returns to IDLE.
    if (tick && pend) begin
      div_nxt  = pend_div;
      pend_nxt = 1'b0;
    end

    if (acc_ok) begin
      if (!busy || tick) begin
        // Idle, or already on a period boundary: the ratio can take effect now
        // without truncating or stretching any period.
        div_nxt = cfg_div;
      end else begin
        pend_nxt     = 1'b1;
        pend_div_nxt = cfg_div;
      end
    end

    busy_nxt    = (state_nxt != IDLE);
    // Computed from next-state values so clk_out lines up with the cnt it describes.
    clk_out_nxt = busy_nxt && (cnt_nxt < div_nxt - (div_nxt >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_div  <= WIDTH'(DEF_DIV);
      pend     <= 1'b0;
      pend_div <= '0;
      cfg_err  <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_div  <= div_nxt;
      pend     <= pend_nxt;
      pend_div <= pend_div_nxt;
      cfg_err  <= err_nxt;
      clk_out  <= clk_out_nxt;
    end
  end

`ifdef FD_SCHED_PERIODS_EN
  logic [15:0] period_cnt;

  always_ff @(posedge clk) begin
    if (rst)       period_cnt <= '0;
    else if (tick) period_cnt <= period_cnt + 16'd1;
  end

  assign periods = period_cnt;
`else
  assign periods = '0;
`endif

endmodule
